// File: rtl/pipe_chain.sv
// Parameterised in-order instruction pipeline with stall/flush boundaries
// and retire/bubble counters on the oldest stage.
module pipe_chain #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int STALL_IDX = 1,
    parameter int FLUSH_IDX = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [31:0]       in_pc,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              in_ready,
    output logic [DEPTH-1:0]  stage_valid_o,
    output logic              out_valid,
    output logic [31:0]       out_pc,
    output logic [WIDTH-1:0]  out_data,
    output logic [31:0]       retire_cnt,
    output logic [31:0]       bubble_cnt
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      pc_d   [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];

    logic [DEPTH-1:0] src_valid;
    logic [31:0]      src_pc   [DEPTH];
    logic [WIDTH-1:0] src_data [DEPTH];

    logic [31:0] retire_cnt_q, retire_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    assign in_ready = ~stall_i & ~flush_i;

    // src_* is what each stage would load on a normal advance; an invalid
    // input is zeroed here so every bubble carries an all-zero payload.
    always_comb begin
        src_valid   = '0;
        src_valid[0] = in_valid;
        src_pc[0]   = in_valid ? in_pc : 32'd0;
        src_data[0] = in_valid ? in_data : '0;
        for (int k = 1; k < DEPTH; k++) begin
            src_valid[k] = valid_q[k-1];
            src_pc[k]    = pc_q[k-1];
            src_data[k]  = data_q[k-1];
        end
    end

    always_comb begin
        valid_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            pc_d[k]   = 32'd0;
            data_d[k] = '0;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (flush_i) begin
                if (k > FLUSH_IDX) begin
                    valid_d[k] = src_valid[k];
                    pc_d[k]    = src_pc[k];
                    data_d[k]  = src_data[k];
                end
            end else if (stall_i) begin
                // Young side freezes; the slot just above it takes a bubble.
                if (k <= STALL_IDX) begin
                    valid_d[k] = valid_q[k];
                    pc_d[k]    = pc_q[k];
                    data_d[k]  = data_q[k];
                end else if (k > STALL_IDX + 1) begin
                    valid_d[k] = src_valid[k];
                    pc_d[k]    = src_pc[k];
                    data_d[k]  = src_data[k];
                end
            end else begin
                valid_d[k] = src_valid[k];
                pc_d[k]    = src_pc[k];
                data_d[k]  = src_data[k];
            end
        end
    end

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (valid_q[DEPTH-1]) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end else begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            retire_cnt_q <= 32'd0;
            bubble_cnt_q <= 32'd0;
            for (int k = 0; k < DEPTH; k++) begin
                pc_q[k]   <= 32'd0;
                data_q[k] <= '0;
            end
        end else begin
            valid_q      <= valid_d;
            retire_cnt_q <= retire_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            for (int k = 0; k < DEPTH; k++) begin
                pc_q[k]   <= pc_d[k];
                data_q[k] <= data_d[k];
            end
        end
    end

    assign stage_valid_o = valid_q;
    assign out_valid     = valid_q[DEPTH-1];
    assign out_pc        = pc_q[DEPTH-1];
    assign out_data      = data_q[DEPTH-1];
    assign retire_cnt    = retire_cnt_q;
    assign bubble_cnt    = bubble_cnt_q;

endmodule
